// File: rtl/edge_frame_buffer.sv
// edge_frame_buffer: double-buffered store for the 1-bit Sobel edge map.
// The writer fills the back bank from the edge stream while the display reads
// the front bank as RGB565. Banks swap only on the display's frame_sync, so a
// frame is never torn on screen.
module edge_frame_buffer #(
  parameter int          HOR_SCREEN  = 800,
  parameter int          VERT_SCREEN = 480,
  parameter int          HOR_PIC     = 160,
  parameter int          VERT_PIC    = 160,
  parameter int          H_START     = 320,
  parameter int          V_START     = 160,
  parameter logic [15:0] EDGE_COLOR  = 16'hFFFF,
  parameter logic [15:0] PIC_BG      = 16'h0000,
  parameter logic [15:0] SCREEN_BG   = 16'h001F
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        edge_data,
  input  logic        edge_valid,
  input  logic        frame_sync,
  input  logic        pix_req,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_done,
  output logic        frame_drop
);

  // The Sobel stage loses one pixel on every side, so the stored map is two
  // smaller than the picture window in each direction.
  localparam int EDGE_W     = HOR_PIC - 2;
  localparam int EDGE_H     = VERT_PIC - 2;
  localparam int FRAME_BITS = EDGE_W * EDGE_H;
  localparam int ADDR_W     = $clog2(FRAME_BITS);
  localparam int COL_W      = $clog2(EDGE_W);
  localparam int ROW_W      = $clog2(EDGE_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(EDGE_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(EDGE_H - 1);

  localparam logic [9:0] SCR_X   = 10'(HOR_SCREEN);
  localparam logic [9:0] SCR_Y   = 10'(VERT_SCREEN);
  localparam logic [9:0] WIN_X0  = 10'(H_START);
  localparam logic [9:0] WIN_X1  = 10'(H_START + HOR_PIC);
  localparam logic [9:0] WIN_Y0  = 10'(V_START);
  localparam logic [9:0] WIN_Y1  = 10'(V_START + VERT_PIC);
  localparam logic [9:0] PX_LAST = 10'(HOR_PIC - 1);
  localparam logic [9:0] PY_LAST = 10'(VERT_PIC - 1);

  logic [COL_W-1:0]  wr_col;
  logic [ROW_W-1:0]  wr_row;
  logic              front;
  logic              full;
  logic              shown;
  logic              wr_en_frame;

  logic [ADDR_W-1:0] wr_addr;
  logic              wrap;
  logic              frame_start;
  logic              swap;
  logic              full_next;

  logic [9:0]        px;
  logic [9:0]        py;
  logic              in_win;
  logic              interior;
  logic [ADDR_W-1:0] rd_addr;

  logic              bank_mem [0:1][0:FRAME_BITS-1];

  // Writer-side decode: write address, frame wrap, and the back-bank full flag
  // for next cycle. A completing frame wins over a swap; the two cannot really
  // coincide because a completing frame implies the back bank was empty.
  always_comb begin
    wr_addr     = ADDR_W'(wr_row) * ADDR_W'(EDGE_W) + ADDR_W'(wr_col);
    wrap        = edge_valid && (wr_col == COL_LAST) && (wr_row == ROW_LAST);
    frame_start = edge_valid && (wr_col == '0) && (wr_row == '0);
    swap        = frame_sync && full;
    full_next   = full;
    if (wrap && wr_en_frame) begin
      full_next = 1'b1;
    end else if (swap) begin
      full_next = 1'b0;
    end
  end

  // Write counters, bank ownership and the frame_done/frame_drop pulses; the
  // write-enable decision is latched once per frame at the wrap pixel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_col      <= '0;
      wr_row      <= '0;
      front       <= 1'b0;
      full        <= 1'b0;
      shown       <= 1'b0;
      wr_en_frame <= 1'b1;
      frame_done  <= 1'b0;
      frame_drop  <= 1'b0;
    end else begin
      frame_done <= wrap && wr_en_frame;
      frame_drop <= frame_start && !wr_en_frame;
      full       <= full_next;
      if (swap) begin
        front <= ~front;
        shown <= 1'b1;
      end
      if (edge_valid) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          if (wr_row == ROW_LAST) begin
            wr_row <= '0;
          end else begin
            wr_row <= wr_row + 1'b1;
          end
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (wrap) begin
        wr_en_frame <= ~full_next;
      end
    end
  end

  // Bit memory write port; always targets the back bank, never the one on screen.
  always_ff @(posedge clk) begin
    if (edge_valid && wr_en_frame) begin
      bank_mem[~front][wr_addr] <= edge_data;
    end
  end

  // Reader-side decode: window hit, 1-pixel border, and front-bank bit address.
  always_comb begin
    px       = pix_x - WIN_X0;
    py       = pix_y - WIN_Y0;
    in_win   = (pix_x < SCR_X) && (pix_y < SCR_Y) &&
               (pix_x >= WIN_X0) && (pix_x < WIN_X1) &&
               (pix_y >= WIN_Y0) && (pix_y < WIN_Y1);
    interior = in_win && (px != 10'd0) && (py != 10'd0) &&
               (px != PX_LAST) && (py != PY_LAST);
    rd_addr  = ADDR_W'(py - 10'd1) * ADDR_W'(EDGE_W) + ADDR_W'(px - 10'd1);
  end

  // Registered pixel output, one cycle after the request; the front bank is
  // only trusted once a completed frame has actually been swapped in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= pix_req;
      if (!pix_req) begin
        pix_data <= '0;
      end else if (!in_win) begin
        pix_data <= SCREEN_BG;
      end else if (interior && shown && bank_mem[front][rd_addr]) begin
        pix_data <= EDGE_COLOR;
      end else begin
        pix_data <= PIC_BG;
      end
    end
  end

endmodule

// File: doc/edge_frame_buffer.md
Name: edge_frame_buffer

Overview:
- Sink for the 1-bit Sobel edge stream, qualified by edge_valid. Stores one complete edge frame per bank in a double-buffered bit memory.
- Serves that frame to the LCD display timing path as RGB565 pixels at a fixed window position on the 800x480 screen.
- Decouples the camera/processing frame rate from the display refresh. Bank swaps happen only at display frame boundaries, so no frame is ever torn on screen.

Parameters:
- HOR_SCREEN, 800, screen width in pixels.
- VERT_SCREEN, 480, screen height in pixels.
- HOR_PIC, 160, picture window width.
- VERT_PIC, 160, picture window height.
- H_START, 320, window left column on screen.
- V_START, 160, window top row on screen.
- EDGE_COLOR, 16'hFFFF, RGB565 colour for an edge pixel.
- PIC_BG, 16'h0000, RGB565 colour for a non-edge pixel inside the window.
- SCREEN_BG, 16'h001F, RGB565 colour outside the window.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- edge_data  input  1  edge bit (1 = edge).
- edge_valid  input  1  edge_data qualifier, one pixel per high cycle.
- frame_sync  input  1  one-cycle pulse from display timing at the start of vertical blank.
- pix_req  input  1  display requests the pixel at pix_x/pix_y.
- pix_x  input  10  display column, 0..HOR_SCREEN-1.
- pix_y  input  10  display row, 0..VERT_SCREEN-1.
- pix_data  output  16  RGB565 pixel.
- pix_valid  output  1  pix_data qualifier.
- frame_done  output  1  one-cycle pulse when a back-bank frame completes.
- frame_drop  output  1  one-cycle pulse when an input frame starts while the back bank is still held.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. Reset values: pix_data=0, pix_valid=0, frame_done=0, frame_drop=0, wr_col=0, wr_row=0, front=0, full=0, shown=0, wr_en_frame=1.
- Edge map geometry:
  - EDGE_W=HOR_PIC-2 and EDGE_H=VERT_PIC-2 (158x158 at defaults). Frame size F=EDGE_W*EDGE_H=24964.
  - Each bank holds F bits. Address = wr_row*EDGE_W + wr_col.
- Writer:
  - Counts edge_valid cycles only; cycles without edge_valid change nothing.
  - wr_col increments and wraps at EDGE_W-1, advancing wr_row. wr_row wraps at EDGE_H-1 to (0,0). The counter always runs, whether or not writes are enabled.
  - The bank write occurs into bank ~front only when wr_en_frame=1.
- Frame boundaries, evaluated at each wrap cycle (valid pixel at position F-1):
  - If wr_en_frame=1: set full=1 and pulse frame_done.
  - Next frame: wr_en_frame <= ~full_next. If that value is 0, pulse frame_drop at the first pixel of the next frame.
- Swap:
  - On frame_sync with full=1 (value before this cycle's update): toggle front, set shown=1, clear full.
  - frame_sync with full=0 is a no-op.
  - If frame_sync coincides with a wrap completion, the swap is not taken this cycle; full becomes 1 and the swap happens at the next frame_sync.
  - A frame already in progress while writes are disabled stays discarded even after a mid-frame swap. Writes resume at the next (0,0).
- Reader (latency 1): pix_valid follows pix_req by one cycle. pix_data is registered and is 0 whenever pix_valid=0.
  - Outside the window: pix_data=SCREEN_BG. The window is H_START<=pix_x<H_START+HOR_PIC and V_START<=pix_y<V_START+VERT_PIC.
  - Inside the window, with local coordinates px=pix_x-H_START and py=pix_y-V_START:
    - On the 1-pixel border (px or py equal to 0 or HOR_PIC-1/VERT_PIC-1): PIC_BG.
    - Otherwise read bit (py-1)*EDGE_W+(px-1) from bank front: EDGE_COLOR if the bit is 1, else PIC_BG.
  - While shown=0, every in-window pixel returns PIC_BG, because bank contents are undefined after reset.
- Memory and simultaneity: a read and a write in the same cycle always target different banks, so there is no hazard. A swap takes effect for reads on the cycle after frame_sync.
- Reset mid-operation: all counters and flags return to their reset values immediately. Bank contents are not cleared.

Test Plan:
- After reset, request (0,0), (320,160) and (400,240) -> pix_data = 16'h001F, 16'h0000, 16'h0000 one cycle later. No frame_done pulses.
- Stream 24964 valid pixels, all 1 except index 0 = 0, with random edge_valid gaps -> frame_done exactly at pixel 24963. Then frame_sync.
  - Read (321,161) -> 16'h0000. Read (322,161) -> 16'hFFFF. Read (320,161) (border) -> 16'h0000.
- Stream two full frames with no frame_sync -> frame 1 sets full. Frame 2 pulses frame_drop at its first pixel and writes nothing.
  - frame_sync then displays frame 1's content.
- Drive frame_sync in the same cycle as the final pixel of a frame -> no swap. The next frame_sync swaps.
- Assert pix_req continuously across the frame_sync swap at (322,161) -> the old bank value is shown up to and including the frame_sync cycle, and the new bank value from the next request onward.
- Assert rstn low mid-frame at pixel 10000 -> all outputs go to 0 immediately.
  - Afterwards a fresh 24964-pixel frame completes normally, with frame_done at its last pixel.
